ser_word_tx: RTL and testbench

- Parallel-to-serial transmit sequencer. Accepts a Length-bit word over a valid/ready handshake and loads it into a shift-register datapath.
- Shifts the word out one bit per programmable bit period, MSB-first or LSB-first, and reports per-bit strobes and end-of-word.
- Sits directly upstream of the serial line driver and drives the ld_en/shift_en/MSB_Out_First controls of its internal shift register.

---
 rtl/ser_word_tx_pkg.sv | 13 +
 rtl/ShiftReg_Variable_Length.sv | 36 +++
 rtl/ser_word_tx.sv | 105 ++++++++++
 tb/tb_ser_word_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_word_tx_pkg.sv
// Shared types and constants for the serial word transmitter.
package ser_word_tx_pkg;

  // Sequencer state encoding
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Level driven on the serial line when no word is being sent
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/ShiftReg_Variable_Length.sv
// Loadable bidirectional shift register with serial fill and both end taps.
module ShiftReg_Variable_Length #(
  parameter int unsigned Length = 8
) (
  input  logic              clk,
  input  logic              sres,
  input  logic              ld_en,
  input  logic [Length-1:0] D,
  input  logic              shift_en,
  input  logic              MSB_Out_First,
  input  logic              Ser_In,
  output logic              MSB_Out,
  output logic              LSB_Out
);

  logic [Length-1:0] data_q;

  // Load has priority over shift; MSB_Out_First picks the shift direction
  always_ff @(posedge clk) begin
    if (sres) begin
      data_q <= '0;
    end else if (ld_en) begin
      data_q <= D;
    end else if (shift_en) begin
      if (MSB_Out_First) begin
        data_q <= {data_q[Length-2:0], Ser_In};
      end else begin
        data_q <= {Ser_In, data_q[Length-1:1]};
      end
    end
  end

  assign MSB_Out = data_q[Length-1];
  assign LSB_Out = data_q[0];

endmodule

// File: rtl/ser_word_tx.sv
// Parallel-to-serial transmit sequencer with programmable bit period.
module ser_word_tx
  import ser_word_tx_pkg::*;
#(
  parameter int unsigned Length    = 8,
  parameter int unsigned Div_Width = 16
) (
  input  logic                 clk,
  input  logic                 sres,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [Length-1:0]    tx_data,
  input  logic                 msb_first,
  input  logic [Div_Width-1:0] bit_div,
  output logic                 ser_out,
  output logic                 ser_active,
  output logic                 bit_strobe,
  output logic                 tx_done
);

  localparam int unsigned CntW = (Length > 1) ? $clog2(Length) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Length - 1);

  state_e               state_q;
  logic [CntW-1:0]      bit_cnt_q;
  logic [Div_Width-1:0] timer_q;
  logic [Div_Width-1:0] div_q;
  logic                 dir_q;
  logic                 ser_active_q;
  logic                 bit_strobe_q;
  logic                 tx_done_q;

  logic in_shift;
  logic timer_zero;
  logic last_bit_end;
  logic accept;
  logic shift_en;
  logic sr_msb;
  logic sr_lsb;

  // Handshake and shift strobes derived from the current control state
  assign in_shift     = (state_q == ST_SHIFT);
  assign timer_zero   = (timer_q == '0);
  assign last_bit_end = in_shift && timer_zero && (bit_cnt_q == LastCnt);
  assign tx_ready     = !sres && ((state_q == ST_IDLE) || last_bit_end);
  assign accept       = tx_valid && tx_ready;
  assign shift_en     = !sres && in_shift && timer_zero && (bit_cnt_q != LastCnt);

  // Sequencer: accept, bit timing, bit counting and registered status pulses
  always_ff @(posedge clk) begin
    if (sres) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      timer_q      <= '0;
      div_q        <= '0;
      dir_q        <= 1'b1;
      ser_active_q <= 1'b0;
      bit_strobe_q <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      bit_strobe_q <= accept || shift_en;
      tx_done_q    <= last_bit_end;
      if (accept) begin
        state_q      <= ST_SHIFT;
        bit_cnt_q    <= '0;
        timer_q      <= bit_div;
        div_q        <= bit_div;
        dir_q        <= msb_first;
        ser_active_q <= 1'b1;
      end else if (in_shift) begin
        if (!timer_zero) begin
          timer_q <= timer_q - Div_Width'(1);
        end else if (bit_cnt_q != LastCnt) begin
          bit_cnt_q <= bit_cnt_q + CntW'(1);
          timer_q   <= div_q;
        end else begin
          state_q      <= ST_IDLE;
          ser_active_q <= 1'b0;
        end
      end
    end
  end

  // Datapath register holding the word in flight
  ShiftReg_Variable_Length #(
    .Length (Length)
  ) u_shift (
    .clk           (clk),
    .sres          (sres),
    .ld_en         (accept),
    .D             (tx_data),
    .shift_en      (shift_en),
    .MSB_Out_First (dir_q),
    .Ser_In        (1'b0),
    .MSB_Out       (sr_msb),
    .LSB_Out       (sr_lsb)
  );

  // Line level: selected register end while shifting, idle level otherwise
  assign ser_out    = in_shift ? (dir_q ? sr_msb : sr_lsb) : LINE_IDLE;
  assign ser_active = ser_active_q;
  assign bit_strobe = bit_strobe_q;
  assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_ser_word_tx.sv
// Directed self-checking bench for ser_word_tx (Length=8, Div_Width=4).
module tb_ser_word_tx;

  localparam int unsigned L  = 8;
  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          sres;
  logic          tx_valid;
  logic          tx_ready;
  logic [L-1:0]  tx_data;
  logic          msb_first;
  logic [DW-1:0] bit_div;
  logic          ser_out;
  logic          ser_active;
  logic          bit_strobe;
  logic          tx_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ser_word_tx #(
    .Length    (L),
    .Div_Width (DW)
  ) dut (
    .clk        (clk),
    .sres       (sres),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .msb_first  (msb_first),
    .bit_div    (bit_div),
    .ser_out    (ser_out),
    .ser_active (ser_active),
    .bit_strobe (bit_strobe),
    .tx_done    (tx_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_word(input logic [L-1:0] d, input logic m, input logic [DW-1:0] dv);
    tx_valid  = 1'b1;
    tx_data   = d;
    msb_first = m;
    bit_div   = dv;
  endtask

  task automatic test_reset();
    sres = 1'b1;
    tick();
    tick();
    total_cnt++; if (ser_out !== 1'b1) $display("FAIL reset.ser_out got %b exp 1", ser_out); else pass_cnt++;
    total_cnt++; if (ser_active !== 1'b0) $display("FAIL reset.ser_active got %b exp 0", ser_active); else pass_cnt++;
    total_cnt++; if (bit_strobe !== 1'b0) $display("FAIL reset.bit_strobe got %b exp 0", bit_strobe); else pass_cnt++;
    total_cnt++; if (tx_done !== 1'b0) $display("FAIL reset.tx_done got %b exp 0", tx_done); else pass_cnt++;
    total_cnt++; if (tx_ready !== 1'b0) $display("FAIL reset.tx_ready_in_reset got %b exp 0", tx_ready); else pass_cnt++;
    sres = 1'b0;
    #1;
    total_cnt++; if (tx_ready !== 1'b1) $display("FAIL reset.tx_ready_idle got %b exp 1", tx_ready); else pass_cnt++;
    tick();
  endtask

  task automatic test_msb_basic();
    logic [1:8] seq;
    logic e_ser, e_rdy;
    seq = 8'b1010_0101;
    start_word(8'hA5, 1'b1, 4'd0);
    tick();
    tx_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      e_ser = (c <= 8) ? seq[c] : 1'b1;
      e_rdy = (c >= 8);
      total_cnt++; if (ser_out !== e_ser) $display("FAIL msb_basic.ser_out c=%0d got %b exp %b", c, ser_out, e_ser); else pass_cnt++;
      total_cnt++; if (bit_strobe !== (c <= 8)) $display("FAIL msb_basic.bit_strobe c=%0d got %b exp %b", c, bit_strobe, c <= 8); else pass_cnt++;
      total_cnt++; if (tx_done !== (c == 9)) $display("FAIL msb_basic.tx_done c=%0d got %b exp %b", c, tx_done, c == 9); else pass_cnt++;
      total_cnt++; if (tx_ready !== e_rdy) $display("FAIL msb_basic.tx_ready c=%0d got %b exp %b", c, tx_ready, e_rdy); else pass_cnt++;
      total_cnt++; if (ser_active !== (c <= 8)) $display("FAIL msb_basic.ser_active c=%0d got %b exp %b", c, ser_active, c <= 8); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_lsb_div();
    logic [0:7] seq;
    logic e_ser, e_stb;
    seq = 8'b1000_0001;
    start_word(8'h81, 1'b0, 4'd2);
    tick();
    tx_valid = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      e_ser = (c <= 24) ? seq[(c - 1) / 3] : 1'b1;
      e_stb = (c <= 24) && (((c - 1) % 3) == 0);
      total_cnt++; if (ser_out !== e_ser) $display("FAIL lsb_div.ser_out c=%0d got %b exp %b", c, ser_out, e_ser); else pass_cnt++;
      total_cnt++; if (bit_strobe !== e_stb) $display("FAIL lsb_div.bit_strobe c=%0d got %b exp %b", c, bit_strobe, e_stb); else pass_cnt++;
      total_cnt++; if (tx_done !== (c == 25)) $display("FAIL lsb_div.tx_done c=%0d got %b exp %b", c, tx_done, c == 25); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic e_ser, e_stb, e_rdy;
    int done_cnt;
    done_cnt = 0;
    start_word(8'hFF, 1'b1, 4'd1);
    tick();
    tx_data = 8'h00;
    for (int c = 1; c <= 33; c++) begin
      e_ser = (c <= 16) || (c == 33);
      e_stb = (c <= 32) && (((c - 1) % 2) == 0);
      e_rdy = (c == 16) || (c >= 32);
      if (c <= 32 && tx_done === 1'b1) done_cnt++;
      total_cnt++; if (ser_out !== e_ser) $display("FAIL b2b.ser_out c=%0d got %b exp %b", c, ser_out, e_ser); else pass_cnt++;
      total_cnt++; if (bit_strobe !== e_stb) $display("FAIL b2b.bit_strobe c=%0d got %b exp %b", c, bit_strobe, e_stb); else pass_cnt++;
      total_cnt++; if (ser_active !== (c <= 32)) $display("FAIL b2b.ser_active c=%0d got %b exp %b", c, ser_active, c <= 32); else pass_cnt++;
      total_cnt++; if (tx_done !== (c == 17 || c == 33)) $display("FAIL b2b.tx_done c=%0d got %b exp %b", c, tx_done, c == 17 || c == 33); else pass_cnt++;
      total_cnt++; if (tx_ready !== e_rdy) $display("FAIL b2b.tx_ready c=%0d got %b exp %b", c, tx_ready, e_rdy); else pass_cnt++;
      if (c == 17) tx_valid = 1'b0;
      tick();
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL b2b.done_pulses got %0d exp 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    logic [0:7] seq;
    logic [0:7] seq2;
    seq  = 8'b0011_1100;
    seq2 = 8'b0101_1010;
    start_word(8'h3C, 1'b1, 4'd0);
    tick();
    tx_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      total_cnt++; if (ser_out !== seq[c - 1]) $display("FAIL mid_reset.pre_ser_out c=%0d got %b exp %b", c, ser_out, seq[c - 1]); else pass_cnt++;
      if (c < 4) tick();
    end
    sres = 1'b1;
    #1;
    total_cnt++; if (tx_ready !== 1'b0) $display("FAIL mid_reset.tx_ready_in_reset got %b exp 0", tx_ready); else pass_cnt++;
    tick();
    total_cnt++; if (ser_out !== 1'b1) $display("FAIL mid_reset.ser_out got %b exp 1", ser_out); else pass_cnt++;
    total_cnt++; if (ser_active !== 1'b0) $display("FAIL mid_reset.ser_active got %b exp 0", ser_active); else pass_cnt++;
    total_cnt++; if (bit_strobe !== 1'b0) $display("FAIL mid_reset.bit_strobe got %b exp 0", bit_strobe); else pass_cnt++;
    sres = 1'b0;
    for (int c = 0; c < 10; c++) begin
      total_cnt++; if (tx_done !== 1'b0) $display("FAIL mid_reset.no_done c=%0d got %b exp 0", c, tx_done); else pass_cnt++;
      total_cnt++; if (ser_out !== 1'b1) $display("FAIL mid_reset.idle_line c=%0d got %b exp 1", c, ser_out); else pass_cnt++;
      tick();
    end
    start_word(8'h5A, 1'b0, 4'd0);
    tick();
    tx_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      total_cnt++; if (ser_out !== ((c <= 8) ? seq2[c - 1] : 1'b1)) $display("FAIL mid_reset.new_ser_out c=%0d got %b exp %b", c, ser_out, (c <= 8) ? seq2[c - 1] : 1'b1); else pass_cnt++;
      total_cnt++; if (tx_done !== (c == 9)) $display("FAIL mid_reset.new_tx_done c=%0d got %b exp %b", c, tx_done, c == 9); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_stability();
    logic [0:7] seq;
    logic [0:7] seq2;
    logic e_ser, e_stb;
    seq  = 8'b1100_0011;
    seq2 = 8'b0011_1100;
    start_word(8'hC3, 1'b1, 4'd1);
    tick();
    tx_valid  = 1'b0;
    tx_data   = 8'h3C;
    msb_first = 1'b0;
    bit_div   = 4'd0;
    for (int c = 1; c <= 17; c++) begin
      e_ser = (c <= 16) ? seq[(c - 1) / 2] : 1'b1;
      e_stb = (c <= 16) && (((c - 1) % 2) == 0);
      total_cnt++; if (ser_out !== e_ser) $display("FAIL stability.ser_out c=%0d got %b exp %b", c, ser_out, e_ser); else pass_cnt++;
      total_cnt++; if (bit_strobe !== e_stb) $display("FAIL stability.bit_strobe c=%0d got %b exp %b", c, bit_strobe, e_stb); else pass_cnt++;
      total_cnt++; if (tx_done !== (c == 17)) $display("FAIL stability.tx_done c=%0d got %b exp %b", c, tx_done, c == 17); else pass_cnt++;
      tick();
    end
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      e_ser = (c <= 8) ? seq2[c - 1] : 1'b1;
      total_cnt++; if (ser_out !== e_ser) $display("FAIL stability.next_ser_out c=%0d got %b exp %b", c, ser_out, e_ser); else pass_cnt++;
      total_cnt++; if (tx_done !== (c == 9)) $display("FAIL stability.next_tx_done c=%0d got %b exp %b", c, tx_done, c == 9); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_div_extremes();
    logic [0:7]  seq;
    logic [0:15] seq2;
    logic e_ser, e_stb;
    seq  = 8'b1001_0110;
    seq2 = 16'b1111_0000_0000_1111;
    start_word(8'h96, 1'b1, 4'd15);
    tick();
    tx_valid = 1'b0;
    for (int c = 1; c <= 129; c++) begin
      e_ser = (c <= 128) ? seq[(c - 1) / 16] : 1'b1;
      e_stb = (c <= 128) && (((c - 1) % 16) == 0);
      total_cnt++; if (ser_out !== e_ser) $display("FAIL div_max.ser_out c=%0d got %b exp %b", c, ser_out, e_ser); else pass_cnt++;
      total_cnt++; if (bit_strobe !== e_stb) $display("FAIL div_max.bit_strobe c=%0d got %b exp %b", c, bit_strobe, e_stb); else pass_cnt++;
      total_cnt++; if (tx_done !== (c == 129)) $display("FAIL div_max.tx_done c=%0d got %b exp %b", c, tx_done, c == 129); else pass_cnt++;
      total_cnt++; if (tx_ready !== (c >= 128)) $display("FAIL div_max.tx_ready c=%0d got %b exp %b", c, tx_ready, c >= 128); else pass_cnt++;
      tick();
    end
    start_word(8'h0F, 1'b0, 4'd0);
    tick();
    tx_data = 8'hF0;
    for (int c = 1; c <= 17; c++) begin
      e_ser = (c <= 16) ? seq2[c - 1] : 1'b1;
      total_cnt++; if (ser_out !== e_ser) $display("FAIL div_zero.ser_out c=%0d got %b exp %b", c, ser_out, e_ser); else pass_cnt++;
      total_cnt++; if (bit_strobe !== (c <= 16)) $display("FAIL div_zero.bit_strobe c=%0d got %b exp %b", c, bit_strobe, c <= 16); else pass_cnt++;
      total_cnt++; if (ser_active !== (c <= 16)) $display("FAIL div_zero.ser_active c=%0d got %b exp %b", c, ser_active, c <= 16); else pass_cnt++;
      total_cnt++; if (tx_done !== (c == 9 || c == 17)) $display("FAIL div_zero.tx_done c=%0d got %b exp %b", c, tx_done, c == 9 || c == 17); else pass_cnt++;
      if (c == 9) tx_valid = 1'b0;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1);
  end

  initial begin
    sres      = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = '0;
    msb_first = 1'b1;
    bit_div   = '0;
    test_reset();
    test_msb_basic();
    test_lsb_div();
    test_back_to_back();
    test_mid_reset();
    test_stability();
    test_div_extremes();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
